// File: rtl/lpc_post_code_fifo.sv
// LPC data-provider backend: acknowledges every I/O write, captures POST-port writes
// into a FIFO drained over valid/ready, and serves last-code / status reads.
module lpc_post_code_fifo #(
  parameter logic [15:0] POST_ADDR   = 16'h0080,
  parameter logic [15:0] STATUS_ADDR = 16'h0081,
  parameter int          DEPTH_LOG2  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] lpc_addr_i,
  input  logic [7:0]  lpc_wdata_i,
  input  logic        lpc_data_wr_i,
  output logic        lpc_wr_done_o,
  output logic [7:0]  lpc_rdata_o,
  output logic        lpc_data_rd_o,
  input  logic        lpc_rd_done_i,
  output logic [7:0]  code_o,
  output logic        code_valid_o,
  input  logic        code_ready_i,
  output logic        overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                r_state;
  logic                  r_wr_done;
  logic                  r_data_rd;
  logic [7:0]            r_rdata;
  logic [7:0]            r_last_code;
  logic [7:0]            r_code;
  logic                  r_valid;
  logic                  r_overflow;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_status_clr;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [CW-1:0]         w_count_pop;
  logic [CW-1:0]         w_count_nxt;
  logic [4:0]            w_count5;
  logic [7:0]            w_status;
  logic [7:0]            w_rd_mux;

  assign w_push_req   = (r_state == S_IDLE) && lpc_data_wr_i && (lpc_addr_i == POST_ADDR);
  assign w_pop        = r_valid && code_ready_i;
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_drop       = w_push_req && w_full && !w_pop;
  assign w_status_clr = lpc_rd_done_i && (lpc_addr_i == STATUS_ADDR);

  assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + DEPTH_LOG2'(1) : r_rd_ptr;
  assign w_wr_ptr_nxt = w_push ? r_wr_ptr + DEPTH_LOG2'(1) : r_wr_ptr;
  // Entries that already existed before this edge; a fresh push only shows one clock later.
  assign w_count_pop  = w_pop  ? r_count - CW'(1) : r_count;
  assign w_count_nxt  = w_push ? w_count_pop + CW'(1) : w_count_pop;

  assign w_count5 = 5'(r_count);
  assign w_status = {r_overflow, w_full, w_empty, w_count5};

  always_comb begin
    w_rd_mux = 8'hFF;
    if (lpc_addr_i == POST_ADDR) begin
      w_rd_mux = r_last_code;
    end else if (lpc_addr_i == STATUS_ADDR) begin
      w_rd_mux = w_status;
    end
  end

  // Write handshake FSM: one ACK per write strobe, released when the strobe drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_wr_done <= 1'b0;
      r_data_rd <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lpc_data_wr_i) begin
            r_state   <= S_ACK;
            r_wr_done <= 1'b1;
            r_data_rd <= 1'b0;
          end else begin
            r_wr_done <= 1'b0;
            r_data_rd <= 1'b1;
          end
        end
        S_ACK: begin
          if (!lpc_data_wr_i) begin
            r_state   <= S_IDLE;
            r_wr_done <= 1'b0;
            r_data_rd <= 1'b1;
          end else begin
            r_wr_done <= 1'b1;
            r_data_rd <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_wr_done <= 1'b0;
          r_data_rd <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping, head register and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_code      <= 8'h00;
      r_overflow  <= 1'b0;
      r_last_code <= 8'h00;
      r_rdata     <= 8'h00;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_pop != '0);
      r_code   <= (w_count_pop != '0) ? r_mem[w_rd_ptr_nxt] : 8'h00;
      r_rdata  <= w_rd_mux;
      if (w_push_req) begin
        r_last_code <= lpc_wdata_i;
      end
      // Set has priority over a read-to-clear on the same edge.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_status_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wr_ptr] <= lpc_wdata_i;
    end
  end

  assign lpc_wr_done_o = r_wr_done;
  assign lpc_data_rd_o = r_data_rd;
  assign lpc_rdata_o   = r_rdata;
  assign code_o        = r_code;
  assign code_valid_o  = r_valid;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_lpc_post_code_fifo.sv
// Bench for lpc_post_code_fifo: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the POST capture FIFO.
module tb_lpc_post_code_fifo;

  localparam int D = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] lpc_addr_i = 16'h0000;
  logic [7:0]  lpc_wdata_i = 8'h00;
  logic        lpc_data_wr_i = 1'b0;
  logic        lpc_wr_done_o;
  logic [7:0]  lpc_rdata_o;
  logic        lpc_data_rd_o;
  logic        lpc_rd_done_i = 1'b0;
  logic [7:0]  code_o;
  logic        code_valid_o;
  logic        code_ready_i = 1'b0;
  logic        overflow_o;

  lpc_post_code_fifo #(
    .POST_ADDR  (16'h0080),
    .STATUS_ADDR(16'h0081),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lpc_addr_i   (lpc_addr_i),
    .lpc_wdata_i  (lpc_wdata_i),
    .lpc_data_wr_i(lpc_data_wr_i),
    .lpc_wr_done_o(lpc_wr_done_o),
    .lpc_rdata_o  (lpc_rdata_o),
    .lpc_data_rd_o(lpc_data_rd_o),
    .lpc_rd_done_i(lpc_rd_done_i),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .overflow_o   (overflow_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model state: queue of every stored code, plus what the outputs must show.
  logic [7:0] mq[$];
  logic [7:0] m_last, m_code, m_rdata;
  logic       m_ovf, m_busy, m_wr_done, m_rd, m_valid;
  bit         m_init = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cnt, vis;
    bit pop, clr, setov;
    if (rst_i) begin
      mq.delete();
      m_last = 8'h00; m_ovf = 1'b0; m_busy = 1'b0; m_wr_done = 1'b0; m_rd = 1'b0;
      m_valid = 1'b0; m_code = 8'h00; m_rdata = 8'h00; m_init = 1'b1;
    end else if (m_init) begin
      cnt = mq.size();
      if (lpc_addr_i == 16'h0080) m_rdata = m_last;
      else if (lpc_addr_i == 16'h0081) m_rdata = {m_ovf, (cnt == D), (cnt == 0), 5'(cnt)};
      else m_rdata = 8'hFF;
      pop   = m_valid && code_ready_i;
      clr   = lpc_rd_done_i && (lpc_addr_i == 16'h0081);
      setov = 1'b0;
      if (pop) void'(mq.pop_front());
      vis = mq.size();
      if (!m_busy && lpc_data_wr_i) begin
        m_busy = 1'b1;
        if (lpc_addr_i == 16'h0080) begin
          m_last = lpc_wdata_i;
          if (cnt < D || pop) mq.push_back(lpc_wdata_i);
          else setov = 1'b1;
        end
      end else if (m_busy && !lpc_data_wr_i) begin
        m_busy = 1'b0;
      end
      m_wr_done = m_busy;
      m_rd      = !m_busy;
      if (clr) m_ovf = 1'b0;
      if (setov) m_ovf = 1'b1;
      m_valid = (vis != 0);
      m_code  = (vis != 0) ? mq[0] : 8'h00;
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  initial forever begin
    @(negedge clk_i);
    if (m_init) begin
      chk("wr_done", lpc_wr_done_o, m_wr_done);
      chk("data_rd", lpc_data_rd_o, m_rd);
      chk("rdata", lpc_rdata_o, m_rdata);
      chk("code_valid", code_valid_o, m_valid);
      if (m_valid) chk("code", code_o, m_code);
      chk("overflow", overflow_o, m_ovf);
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    lpc_data_wr_i = 1'b0;
    lpc_rd_done_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic lpc_write(input logic [15:0] a, input logic [7:0] d);
    int n;
    lpc_addr_i = a;
    lpc_wdata_i = d;
    lpc_data_wr_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (lpc_wr_done_o !== 1'b1 && n < 20);
    if (n >= 20) chk("wr_done_timeout", 32'(lpc_wr_done_o), 32'd1);
    lpc_data_wr_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (lpc_wr_done_o !== 1'b0 && n < 20);
    if (n >= 20) chk("wr_release_timeout", 32'(lpc_wr_done_o), 32'd0);
  endtask

  task automatic lpc_read(input logic [15:0] a, input bit pulse_done);
    lpc_addr_i = a;
    @(negedge clk_i);
    if (pulse_done) begin
      lpc_rd_done_i = 1'b1;
      @(negedge clk_i);
      lpc_rd_done_i = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] ra;
    int op;

    // Reset values.
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_wr_done", lpc_wr_done_o, 1'b0);
    chk("rst_data_rd", lpc_data_rd_o, 1'b0);
    chk("rst_valid", code_valid_o, 1'b0);
    chk("rst_code", code_o, 8'h00);
    chk("rst_overflow", overflow_o, 1'b0);
    @(negedge clk_i);
    chk("idle_data_rd", lpc_data_rd_o, 1'b1);

    // POST write appears on the stream, then is popped.
    lpc_write(16'h0080, 8'h5A);
    chk("t1_valid", code_valid_o, 1'b1);
    chk("t1_code", code_o, 8'h5A);
    code_ready_i = 1'b1;
    @(negedge clk_i);
    code_ready_i = 1'b0;
    chk("t1_empty", code_valid_o, 1'b0);

    // Non-POST write: acked, not stored, last code kept.
    lpc_write(16'h9696, 8'hA5);
    chk("t2_valid", code_valid_o, 1'b0);
    lpc_read(16'h0080, 1'b0);
    chk("t2_last_code", lpc_rdata_o, 8'h5A);
    lpc_read(16'h0081, 1'b0);
    chk("t2_status", lpc_rdata_o, 8'h20);

    // Overfill: 17 writes with the consumer stalled.
    for (int i = 0; i <= 16; i++) lpc_write(16'h0080, 8'(i));
    chk("t3_overflow", overflow_o, 1'b1);
    lpc_read(16'h0081, 1'b0);
    chk("t3_status", lpc_rdata_o, 8'hD0);
    lpc_read(16'h0080, 1'b0);
    chk("t3_last_code", lpc_rdata_o, 8'h10);

    // Read-to-clear of overflow.
    lpc_addr_i = 16'h0081;
    @(negedge clk_i);
    chk("t5_status_before", lpc_rdata_o, 8'hD0);
    lpc_rd_done_i = 1'b1;
    @(negedge clk_i);
    lpc_rd_done_i = 1'b0;
    chk("t5_overflow_cleared", overflow_o, 1'b0);
    @(negedge clk_i);
    chk("t5_status_after", lpc_rdata_o, 8'h50);

    // Full FIFO, pop coinciding with the push edge: no drop.
    lpc_addr_i = 16'h0080;
    lpc_wdata_i = 8'h11;
    lpc_data_wr_i = 1'b1;
    code_ready_i = 1'b1;
    @(negedge clk_i);
    code_ready_i = 1'b0;
    chk("t4_wr_done", lpc_wr_done_o, 1'b1);
    lpc_data_wr_i = 1'b0;
    @(negedge clk_i);
    chk("t4_overflow", overflow_o, 1'b0);
    lpc_read(16'h0081, 1'b0);
    chk("t4_status", lpc_rdata_o, 8'h50);

    // Drain: 0x01..0x0F then 0x11.
    code_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", code_valid_o, 1'b1);
      chk("drain_code", code_o, (k < 15) ? 32'(k + 1) : 32'h11);
      @(negedge clk_i);
    end
    code_ready_i = 1'b0;
    chk("drain_empty", code_valid_o, 1'b0);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      code_ready_i = ($urandom_range(0, 2) != 0);
      op = $urandom_range(0, 19);
      case ($urandom_range(0, 3))
        0: ra = 16'h0080;
        1: ra = 16'h0081;
        2: ra = 16'h0082;
        default: ra = 16'($urandom);
      endcase
      if (op < 9) begin
        lpc_write((op < 6) ? 16'h0080 : ra, 8'($urandom));
      end else if (op < 15) begin
        lpc_read(ra, ($urandom_range(0, 1) == 1));
      end else if (op == 19 && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
    end
    code_ready_i = 1'b0;

    // Reset in the middle of a long-held write.
    lpc_addr_i = 16'h0080;
    lpc_wdata_i = 8'h77;
    lpc_data_wr_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("t6_wr_done_held", lpc_wr_done_o, 1'b1);
    do_reset();
    chk("t6_wr_done", lpc_wr_done_o, 1'b0);
    chk("t6_data_rd", lpc_data_rd_o, 1'b0);
    chk("t6_valid", code_valid_o, 1'b0);
    chk("t6_code", code_o, 8'h00);
    chk("t6_overflow", overflow_o, 1'b0);
    lpc_read(16'h0081, 1'b0);
    chk("t6_status", lpc_rdata_o, 8'h20);
    chk("t6_data_rd_idle", lpc_data_rd_o, 1'b1);
    lpc_read(16'h0080, 1'b0);
    chk("t6_last_code", lpc_rdata_o, 8'h00);
    repeat (2) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
